// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with an internal FIFO.
// Bytes written through wr_en/wr_data are queued and sent LSB-first as
// start / DATA_BITS data / optional parity / STOP_BITS stop frames, with
// bit timing derived from CLOCK_FREQ/BAUD_RATE. While the FIFO holds data,
// frames are chained with no idle gap.
//
// Optional feature macro: UART_TX_CTS_EN adds the cts_n flow-control input.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write strobe and data to queue
//   full, empty       FIFO status (registered)
//   level             FIFO entry count (registered)
//   overflow          one-cycle pulse after a dropped write
//   busy              a frame is on the line
//   tx                serial output, idle high
//   cts_n             clear-to-send, active low (UART_TX_CTS_EN only)
module uart_tx_fifo #(
   parameter int unsigned CLOCK_FREQ = 30000000,
   parameter int unsigned BAUD_RATE  = 19200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wr_en,
   input  logic [DATA_BITS-1:0]               wr_data,
   output logic                               full,
   output logic                               empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
   output logic                               overflow,
   output logic                               busy,
   output logic                               tx
`ifdef UART_TX_CTS_EN
   ,
   input  logic                               cts_n
`endif
);

   localparam int unsigned DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BW  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state;
   logic [TW-1:0]          timer;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit;

   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;

   logic                   start_ok_c;
   logic                   tick_c;
   logic                   last_stop_c;
   logic                   pop_c;
   logic                   wr_acc_c;
   logic [DATA_BITS-1:0]   head_c;
   logic                   par_c;
   logic [LW-1:0]          level_nxt_c;

`ifdef UART_TX_CTS_EN
   // Two-flop synchronizer; resets to "not clear" so no frame starts early.
   logic [1:0] cts_sync;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cts_sync <= 2'b11;
      else        cts_sync <= {cts_sync[0], cts_n};
   end
   assign start_ok_c = ~cts_sync[1];
`else
   assign start_ok_c = 1'b1;
`endif

   // Bit boundary, last stop-bit cycle and pop decision.
   always_comb begin
      tick_c      = (timer == TW'(DIV - 1));
      last_stop_c = (state == S_STOP) && tick_c && (bit_cnt == BW'(STOP_BITS - 1));
      pop_c       = start_ok_c && !empty && ((state == S_IDLE) || last_stop_c);
      wr_acc_c    = wr_en && !full;
      head_c      = mem[rd_ptr];
      par_c       = (PARITY == 1) ? ~(^head_c) : (^head_c);
      level_nxt_c = level;
      case ({wr_acc_c, pop_c})
         2'b10:   level_nxt_c = level + LW'(1);
         2'b01:   level_nxt_c = level - LW'(1);
         default: level_nxt_c = level;
      endcase
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc_c) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
         level    <= level_nxt_c;
         full     <= (level_nxt_c == LW'(FIFO_DEPTH));
         empty    <= (level_nxt_c == '0);
         overflow <= wr_en && full;
      end
   end

   // Frame state machine with registered tx and busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         timer <= tick_c ? '0 : timer + TW'(1);
         case (state)
            S_IDLE: begin
               timer <= '0;
               if (pop_c) begin
                  state   <= S_START;
                  shreg   <= head_c;
                  par_bit <= par_c;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            S_START: begin
               if (tick_c) begin
                  state   <= S_DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        state <= S_PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (tick_c) begin
                  state   <= S_STOP;
                  tx      <= 1'b1;
                  bit_cnt <= '0;
               end
            end
            S_STOP: begin
               if (tick_c) begin
                  if (bit_cnt == BW'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     // Chain straight into the next start bit when allowed.
                     if (pop_c) begin
                        state   <= S_START;
                        shreg   <= head_c;
                        par_bit <= par_c;
                        tx      <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances sharing the write bus,
// A = 8N1 and B = 7 data bits, odd parity, 2 stop bits; both DIV=8, depth 4.
module tb_uart_tx_fifo;

   localparam int unsigned DIV = 8;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full_a, empty_a, overflow_a, busy_a, tx_a;
   logic       full_b, empty_b, overflow_b, busy_b, tx_b;
   logic [2:0] level_a, level_b;
`ifdef UART_TX_CTS_EN
   logic       cts_n;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int frames[2];
   int gap_sum[2];

   uart_tx_fifo #(
      .CLOCK_FREQ(8000000), .BAUD_RATE(1000000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full_a), .empty(empty_a), .level(level_a), .overflow(overflow_a),
      .busy(busy_a), .tx(tx_a)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   uart_tx_fifo #(
      .CLOCK_FREQ(8000000), .BAUD_RATE(1000000), .DATA_BITS(7),
      .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data[6:0]),
      .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b),
      .busy(busy_b), .tx(tx_b)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Serial monitor: on each start bit pop the expected byte and check every
   // cycle of the frame against the bench-built waveform.
   task automatic monitor(input int which);
      int         gap;
      bit         ended;
      bit         aborted;
      logic [7:0] d;
      logic [15:0] bits;
      int         nb;
      gap   = 0;
      ended = 1'b0;
      forever begin
         step();
         if (!rst_n || ((which == 0) ? tx_a : tx_b) !== 1'b0) begin
            if (ended && rst_n)
               check((which == 0) ? "busy_drop_a" : "busy_drop_b",
                     32'((which == 0) ? busy_a : busy_b), 32'd0);
            ended = 1'b0;
            gap++;
            continue;
         end
         if (frames[which] > 0) gap_sum[which] += gap;
         gap   = 0;
         ended = 1'b0;
         d     = 8'h00;
         if (which == 0) begin
            if (q_a.size() == 0) check("unexpected_frame_a", 32'd1, 32'd0);
            else d = q_a.pop_front();
            bits = 16'({1'b1, d, 1'b0});
            nb   = 10;
         end else begin
            if (q_b.size() == 0) check("unexpected_frame_b", 32'd1, 32'd0);
            else d = q_b.pop_front();
            bits = 16'({2'b11, ~(^d[6:0]), d[6:0], 1'b0});
            nb   = 11;
         end
         aborted = 1'b0;
         for (int c = 0; c < nb * DIV; c++) begin
            if (c > 0) step();
            if (!rst_n) begin
               aborted = 1'b1;
               break;
            end
            check((which == 0) ? "tx_a" : "tx_b",
                  32'((which == 0) ? tx_a : tx_b), 32'(bits[c / DIV]));
            if (c == 0 || c == nb * DIV - 1)
               check((which == 0) ? "busy_in_frame_a" : "busy_in_frame_b",
                     32'((which == 0) ? busy_a : busy_b), 32'd1);
         end
         if (!aborted) begin
            frames[which]++;
            ended = 1'b1;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic push(input logic [7:0] d);
      q_a.push_back(d);
      q_b.push_back({1'b0, d[6:0]});
   endtask

   task automatic clear_counts();
      frames[0]  = 0;
      frames[1]  = 0;
      gap_sum[0] = 0;
      gap_sum[1] = 0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (q_a.size() == 0 && q_b.size() == 0 && !busy_a && !busy_b) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_timeout", 32'(done), 32'd1);
      step();
   endtask

   initial begin
      int exp_lvl[6];
      int lat;
      exp_lvl = '{1, 1, 2, 3, 4, 4};
      clear_counts();
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
`ifdef UART_TX_CTS_EN
      cts_n   = 1'b0;
`endif
      repeat (3) step();

      // Reset state
      check("rst_tx_a", 32'(tx_a), 32'd1);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_full_a", 32'(full_a), 32'd0);
      check("rst_empty_a", 32'(empty_a), 32'd1);
      check("rst_level_a", 32'(level_a), 32'd0);
      check("rst_overflow_a", 32'(overflow_a), 32'd0);
      check("rst_tx_b", 32'(tx_b), 32'd1);
      check("rst_empty_b", 32'(empty_b), 32'd1);
      rst_n = 1'b1;
      repeat (4) step();

      // Single byte: write-to-line latency and full frame shape
      wr_en   = 1'b1;
      wr_data = 8'h41;
      push(8'h41);
      step();
      wr_en = 1'b0;
      check("lat_empty_k", 32'(empty_a), 32'd0);
      check("lat_level_k", 32'(level_a), 32'd1);
      check("lat_tx_k", 32'(tx_a), 32'd1);
      check("lat_busy_k", 32'(busy_a), 32'd0);
      step();
      check("lat_tx_k1", 32'(tx_a), 32'd0);
      check("lat_busy_k1", 32'(busy_a), 32'd1);
      check("lat_level_k1", 32'(level_a), 32'd0);
      check("lat_empty_k1", 32'(empty_a), 32'd1);
      check("lat_tx_b_k1", 32'(tx_b), 32'd0);
      wait_drain();
      check("single_frames_a", 32'(frames[0]), 32'd1);
      check("single_frames_b", 32'(frames[1]), 32'd1);

      // Burst of 6 into a depth-4 FIFO: one drop, 5 back-to-back frames
      repeat (5) step();
      clear_counts();
      for (int i = 0; i < 6; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(8'h10 + i);
         if (i < 5) push(8'(8'h10 + i));
         step();
         check("burst_level_a", 32'(level_a), 32'(exp_lvl[i]));
         check("burst_level_b", 32'(level_b), 32'(exp_lvl[i]));
         check("burst_full_a", 32'(full_a), 32'(i >= 4));
         check("burst_overflow_a", 32'(overflow_a), 32'(i == 5));
         check("burst_overflow_b", 32'(overflow_b), 32'(i == 5));
      end
      wr_en = 1'b0;
      step();
      check("overflow_single_pulse", 32'(overflow_a), 32'd0);
      check("overflow_level_kept", 32'(level_a), 32'd4);
      wait_drain();
      check("burst_frames_a", 32'(frames[0]), 32'd5);
      check("burst_frames_b", 32'(frames[1]), 32'd5);
      check("burst_gap_a", 32'(gap_sum[0]), 32'd0);
      check("burst_gap_b", 32'(gap_sum[1]), 32'd0);
      check("burst_level_end", 32'(level_a), 32'd0);
      check("burst_empty_end", 32'(empty_a), 32'd1);

      // Reset in the middle of DATA with 3 entries queued
      repeat (5) step();
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(8'hA0 + i);
         push(8'(8'hA0 + i));
         step();
      end
      wr_en = 1'b0;
      check("pre_rst_level", 32'(level_a), 32'd3);
      repeat (30) step();
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_a", 32'(tx_a), 32'd1);
      check("mid_rst_busy_a", 32'(busy_a), 32'd0);
      check("mid_rst_level_a", 32'(level_a), 32'd0);
      check("mid_rst_empty_a", 32'(empty_a), 32'd1);
      check("mid_rst_tx_b", 32'(tx_b), 32'd1);
      q_a.delete();
      q_b.delete();
      repeat (3) step();
      rst_n = 1'b1;
      clear_counts();
      repeat (200) step();
      check("post_rst_frames_a", 32'(frames[0]), 32'd0);
      check("post_rst_frames_b", 32'(frames[1]), 32'd0);
      check("post_rst_tx_a", 32'(tx_a), 32'd1);
      check("post_rst_empty_a", 32'(empty_a), 32'd1);

`ifdef UART_TX_CTS_EN
      // Flow control: hold while cts_n high, release, hold again mid-frame
      clear_counts();
      cts_n = 1'b1;
      repeat (4) step();
      wr_en   = 1'b1;
      wr_data = 8'h55;
      push(8'h55);
      step();
      wr_data = 8'h56;
      push(8'h56);
      step();
      wr_en = 1'b0;
      repeat (40) step();
      check("cts_hold_tx", 32'(tx_a), 32'd1);
      check("cts_hold_busy", 32'(busy_a), 32'd0);
      check("cts_hold_level", 32'(level_a), 32'd2);
      cts_n = 1'b0;
      lat   = 7;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (tx_a === 1'b0) begin
            lat = i;
            break;
         end
      end
      check("cts_start_lat", 32'(lat <= 3), 32'd1);
      repeat (20) step();
      cts_n = 1'b1;
      repeat (250) step();
      check("cts_mid_frames_a", 32'(frames[0]), 32'd1);
      check("cts_mid_frames_b", 32'(frames[1]), 32'd1);
      check("cts_mid_level", 32'(level_a), 32'd1);
      check("cts_mid_busy", 32'(busy_a), 32'd0);
      cts_n = 1'b0;
      wait_drain();
      check("cts_end_frames_a", 32'(frames[0]), 32'd2);
      check("cts_end_frames_b", 32'(frames[1]), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
